// File: rtl/vga_hvsync_generator.sv
// VGA 640x480@60Hz timing generator: pixel/line counters, active-low syncs
// and a visible-area flag for the downstream pixel pipeline.
module vga_hvsync_generator #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_BOTTOM  = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_TOP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_DISP       = 10'(H_DISPLAY);
    localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_DISP       = 10'(V_DISPLAY);
    localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC);

    logic [9:0] r_hpos;
    logic [9:0] r_vpos;
    logic       r_hsync;
    logic       r_vsync;

    logic       w_h_wrap;
    logic [9:0] w_hpos_next;
    logic [9:0] w_vpos_next;
    logic       w_hsync_next;
    logic       w_vsync_next;

    // Next-state counters; >= so an out-of-range value recovers at the next wrap check.
    always_comb begin
        w_h_wrap    = (r_hpos >= H_LAST);
        w_hpos_next = w_h_wrap ? 10'd0 : r_hpos + 10'd1;
        w_vpos_next = r_vpos;
        if (w_h_wrap) begin
            w_vpos_next = (r_vpos >= V_LAST) ? 10'd0 : r_vpos + 10'd1;
        end
        // Syncs decoded from next-state position so the registered pulse lines up with hpos/vpos.
        w_hsync_next = !((w_hpos_next >= H_SYNC_START) && (w_hpos_next < H_SYNC_END));
        w_vsync_next = !((w_vpos_next >= V_SYNC_START) && (w_vpos_next < V_SYNC_END));
    end

    // Counter and sync registers; reset parks at (0,0) with syncs inactive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hpos  <= 10'd0;
            r_vpos  <= 10'd0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_hpos  <= w_hpos_next;
            r_vpos  <= w_vpos_next;
            r_hsync <= w_hsync_next;
            r_vsync <= w_vsync_next;
        end
    end

    assign hpos       = r_hpos;
    assign vpos       = r_vpos;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign display_on = (r_hpos < H_DISP) && (r_vpos < V_DISP);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Bench for vga_hvsync_generator: a full-size instance for line timing and a
// vertically shortened instance (15-line frame) to reach frame-level events quickly.
module tb_vga_hvsync_generator;

    typedef struct {
        int unsigned k;     // clocks after reset release
        bit          sel;   // 0: full instance, 1: short-frame instance
        int unsigned h;
        int unsigned v;
        bit          hs;
        bit          vs;
        bit          de;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       f_hsync, f_vsync, f_de;
    logic [9:0] f_hpos, f_vpos;
    logic       s_hsync, s_vsync, s_de;
    logic [9:0] s_hpos, s_vpos;

    int n_checks;
    int n_fail;
    int unsigned cur_k;
    vec_t sb[$];

    vga_hvsync_generator u_full (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync      (f_hsync),
        .vsync      (f_vsync),
        .display_on (f_de),
        .hpos       (f_hpos),
        .vpos       (f_vpos)
    );

    vga_hvsync_generator #(
        .V_DISPLAY (8),
        .V_BOTTOM  (2),
        .V_SYNC    (2),
        .V_TOP     (3)
    ) u_short (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .display_on (s_de),
        .hpos       (s_hpos),
        .vpos       (s_vpos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timing computed from clock count since release.
    function automatic vec_t mk(input bit sel, input int unsigned k);
        vec_t        r;
        int unsigned vtot, vss, vdisp;
        vtot  = sel ? 15 : 525;
        vss   = sel ? 10 : 490;
        vdisp = sel ? 8 : 480;
        r.k   = k;
        r.sel = sel;
        r.h   = k % 800;
        r.v   = (k / 800) % vtot;
        r.hs  = !((r.h >= 656) && (r.h < 752));
        r.vs  = !((r.v >= vss) && (r.v < vss + 2));
        r.de  = (r.h < 640) && (r.v < vdisp);
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input bit sel, input int h, input int v,
                               input bit hs, input bit vs, input bit de);
        if (!sel) begin
            chk({tag, " full hpos"}, int'(f_hpos), h);
            chk({tag, " full vpos"}, int'(f_vpos), v);
            chk({tag, " full hsync"}, int'(f_hsync), int'(hs));
            chk({tag, " full vsync"}, int'(f_vsync), int'(vs));
            chk({tag, " full display_on"}, int'(f_de), int'(de));
        end else begin
            chk({tag, " short hpos"}, int'(s_hpos), h);
            chk({tag, " short vpos"}, int'(s_vpos), v);
            chk({tag, " short hsync"}, int'(s_hsync), int'(hs));
            chk({tag, " short vsync"}, int'(s_vsync), int'(vs));
            chk({tag, " short display_on"}, int'(s_de), int'(de));
        end
    endtask

    task automatic advance_to(input int unsigned k);
        while (cur_k < k) begin
            @(posedge clk);
            cur_k++;
        end
        #1;
    endtask

    localparam int NV = 23;
    int unsigned ks[NV] = '{0, 0, 1, 2, 3, 639, 640, 655, 656, 751, 752, 799, 800, 1599,
                            6239, 6240, 6400, 7999, 8000, 9599, 9600, 11999, 12000};
    bit          ss[NV] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                            1, 1, 1, 1, 1, 1, 1, 1, 1};

    initial begin
        vec_t tbl[NV];
        vec_t e;
        int   hs_low, vs_low, vs_rise, vs_fall_k;
        bit   prev_vs;

        n_checks = 0;
        n_fail   = 0;
        cur_k    = 0;
        for (int i = 0; i < NV; i++) tbl[i] = mk(ss[i], ks[i]);

        // Reset held with clock running.
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_outputs("reset", 1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
        chk_outputs("reset", 1'b1, 0, 0, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;

        // Table-driven checkpoints through one short frame and into the next.
        for (int i = 0; i < NV; i++) begin
            advance_to(tbl[i].k);
            sb.push_back(tbl[i]);
            e = sb.pop_front();
            chk_outputs($sformatf("k=%0d", e.k), e.sel, int'(e.h), int'(e.v), e.hs, e.vs, e.de);
        end

        // One whole short frame: hsync low count, vsync low count, one vsync rise.
        hs_low    = 0;
        vs_low    = 0;
        vs_rise   = 0;
        vs_fall_k = 0;
        prev_vs   = s_vsync;
        for (int c = 0; c < 12000; c++) begin
            @(posedge clk);
            cur_k++;
            #1;
            if (!f_hsync) hs_low++;
            if (!s_vsync) vs_low++;
            if (s_vsync && !prev_vs) vs_rise++;
            if (!s_vsync && prev_vs) vs_fall_k = int'(cur_k);
            prev_vs = s_vsync;
        end
        chk("hsync low clocks over 15 lines", hs_low, 15 * 96);
        chk("vsync low clocks per frame", vs_low, 1600);
        chk("vsync rising edges per frame", vs_rise, 1);
        chk("vsync falling edge clock", vs_fall_k, 20000);

        // Async reset mid-frame at hpos=700 on the first vsync line.
        advance_to(24000 + 8000 + 700);
        chk_outputs("pre-reset", 1'b1, 700, 10, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs("async reset", 1'b1, 0, 0, 1'b1, 1'b1, 1'b1);
        chk_outputs("async reset", 1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_outputs("restart+1", 1'b1, 1, 0, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk_outputs("restart+2", 1'b0, 2, 0, 1'b1, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
